// File: rtl/note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : note_sequencer                                                  |
// | Function : FIFO-buffered step sequencer driving per-track note/amplitude.  |
// |            Optional macro SEQ_GAP_EN silences the final tick of D>=2 steps.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module note_sequencer #(
  parameter int NUM_TRACKS  = 1,
  parameter int PACKET_SIZE = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int TICK_DIV    = 2500000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pkt_valid,
  input  logic [PACKET_SIZE*NUM_TRACKS-1:0]   pkt_data,
  output logic                                pkt_ready,
  output logic [8*NUM_TRACKS-1:0]             note,
  output logic [8*NUM_TRACKS-1:0]             amp,
  output logic                                note_strobe,
  output logic                                playing,
  output logic                                underrun,
  output logic [$clog2(FIFO_DEPTH):0]         fill
);

  localparam int c_PW = PACKET_SIZE * NUM_TRACKS;
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_FW = c_AW + 1;
  localparam int c_TW = $clog2(TICK_DIV);

  localparam logic [c_TW-1:0] c_TICK_LAST    = c_TW'(TICK_DIV - 1);
  localparam logic [c_TW-1:0] c_TICK_PRELOAD = c_TW'(TICK_DIV - 2);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_PLAY = 2'd2;

`ifdef SEQ_GAP_EN
  localparam bit c_GAP_EN = 1'b1;
`else
  localparam bit c_GAP_EN = 1'b0;
`endif

  logic [c_PW-1:0]         r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]         r_wr_ptr;
  logic [c_AW-1:0]         r_rd_ptr;
  logic [c_FW-1:0]         r_fill;

  logic [1:0]              r_state;
  logic [c_TW-1:0]         r_tick;
  logic [8:0]              r_rem;
  logic [8*NUM_TRACKS-1:0] r_note;
  logic [8*NUM_TRACKS-1:0] r_amp;
  logic                    r_strobe;
  logic                    r_playing;
  logic                    r_underrun;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_nonempty;
  logic [c_PW-1:0]         w_head;
  logic [8*NUM_TRACKS-1:0] w_head_note;
  logic [8*NUM_TRACKS-1:0] w_head_amp;
  logic [7:0]              w_head_dur;
  logic [8:0]              w_load_rem;

  assign pkt_ready       = (r_fill < c_FW'(FIFO_DEPTH));
  assign w_fifo_nonempty = (r_fill != '0);
  assign w_push          = pkt_valid && pkt_ready;
  assign w_pop           = (r_state == c_LOAD) && w_fifo_nonempty;

  // Packet buffer storage; contents need no reset, pointers do.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pkt_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + c_FW'(1);
        2'b01:   r_fill <= r_fill - c_FW'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
    assign w_head_note[8*t +: 8] = w_head[PACKET_SIZE*t + 8 +: 8];
    assign w_head_amp[8*t +: 8]  = w_head[PACKET_SIZE*t +: 8];
  end

  // Only track 0 carries the step duration; zero encodes 256 ticks.
  assign w_head_dur = w_head[16 +: 8];
  assign w_load_rem = (w_head_dur == 8'd0) ? 9'd256 : {1'b0, w_head_dur};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_IDLE;
      r_tick     <= '0;
      r_rem      <= '0;
      r_note     <= '0;
      r_amp      <= '0;
      r_strobe   <= 1'b0;
      r_playing  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_fifo_nonempty) begin
            r_state <= c_LOAD;
          end
        end

        c_LOAD: begin
          r_note    <= w_head_note;
          r_amp     <= w_head_amp;
          r_rem     <= w_load_rem;
          r_tick    <= '0;
          r_strobe  <= 1'b1;
          r_playing <= 1'b1;
          r_state   <= c_PLAY;
        end

        c_PLAY: begin
          if (r_tick == c_TICK_LAST) begin
            r_tick <= '0;
            if (r_rem == 9'd1) begin
              // Reached only when the next packet arrived too late to preload.
              if (w_fifo_nonempty) begin
                r_state <= c_LOAD;
              end else begin
                r_state    <= c_IDLE;
                r_playing  <= 1'b0;
                r_amp      <= '0;
                r_underrun <= 1'b1;
              end
            end else begin
              r_rem <= r_rem - 9'd1;
              if (c_GAP_EN && (r_rem == 9'd2)) begin
                r_amp <= '0;
              end
            end
          end else begin
            r_tick <= r_tick + c_TW'(1);
            // Enter LOAD one cycle early so the next step lands exactly on the tick boundary.
            if ((r_rem == 9'd1) && (r_tick == c_TICK_PRELOAD) && w_fifo_nonempty) begin
              r_state <= c_LOAD;
            end
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign note        = r_note;
  assign amp         = r_amp;
  assign note_strobe = r_strobe;
  assign playing     = r_playing;
  assign underrun    = r_underrun;
  assign fill        = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// Scoreboard bench for note_sequencer: stimulus queues expected strobes,
// a negedge monitor pops and compares them; level checks run inline.
module tb_note_sequencer;

  localparam int T = 4;
`ifdef SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        pkt_valid;
  logic [23:0] pkt_data;
  logic        pkt_ready;
  logic [7:0]  note;
  logic [7:0]  amp;
  logic        note_strobe;
  logic        playing;
  logic        underrun;
  logic [2:0]  fill;

  note_sequencer #(
    .NUM_TRACKS (1),
    .PACKET_SIZE(24),
    .FIFO_DEPTH (4),
    .TICK_DIV   (T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_ready  (pkt_ready),
    .note       (note),
    .amp        (amp),
    .note_strobe(note_strobe),
    .playing    (playing),
    .underrun   (underrun),
    .fill       (fill)
  );

  typedef struct {
    logic [7:0] note;
    logic [7:0] amp;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && note_strobe) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_note",  64'(note), 64'(e.note));
        check("strobe_amp",   64'(amp),  64'(e.amp));
        check("strobe_cycle", 64'(cyc),  64'(e.at));
      end
    end
  end

  task automatic wait_to(input int k);
    do @(negedge clk); while (cyc < k);
  endtask

  // Called at a negedge; returns the clock edge number on which the packet was accepted.
  task automatic push(input logic [23:0] d, output int acc);
    int waited;
    waited    = 0;
    pkt_data  = d;
    pkt_valid = 1'b1;
    while (!pkt_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!pkt_ready) begin
      check("push_timeout", 64'd1, 64'd0);
      acc = -1;
    end else begin
      acc = cyc + 1;
    end
    @(negedge clk);
    pkt_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, s, s0;
    logic [23:0] d;

    reset = 1'b0; pkt_valid = 1'b0; pkt_data = '0;
    repeat (3) @(negedge clk);
    check("rst_hold_amp",  64'(amp),  64'd0);
    check("rst_hold_fill", 64'(fill), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_note",     64'(note),        64'd0);
    check("rst_amp",      64'(amp),         64'd0);
    check("rst_fill",     64'(fill),        64'd0);
    check("rst_ready",    64'(pkt_ready),   64'd1);
    check("rst_playing",  64'(playing),     64'd0);
    check("rst_underrun", 64'(underrun),    64'd0);
    check("rst_strobe",   64'(note_strobe), 64'd0);

    // Single D=2 step from idle, ends in underrun.
    push(24'h0214ff, acc);
    s = acc + 2;
    sb.push_back('{8'h14, 8'hff, s});
    wait_to(s + 3);
    check("d2_amp_early",  64'(amp),     64'hff);
    check("d2_playing",    64'(playing), 64'd1);
    wait_to(s + 4);
    check("d2_amp_final_tick", 64'(amp), GAP ? 64'd0 : 64'hff);
    check("d2_note_held",  64'(note),    64'h14);
    wait_to(s + 7);
    check("d2_amp_last",   64'(amp),      GAP ? 64'd0 : 64'hff);
    check("d2_no_underrun_yet", 64'(underrun), 64'd0);
    wait_to(s + 8);
    check("d2_amp_off",    64'(amp),      64'd0);
    check("d2_idle",       64'(playing),  64'd0);
    check("d2_underrun",   64'(underrun), 64'd1);
    check("d2_note_kept",  64'(note),     64'h14);

    // D=1 step followed by five queued packets; FIFO fills and back-pressures.
    push(24'h0110ff, acc);
    s0 = acc + 2;
    sb.push_back('{8'h10, 8'hff, s0});
    for (int k = 1; k <= 5; k++) begin
      d = {8'h01, 8'(8'h10 + k), 8'(8'ha0 + k)};
      sb.push_back('{8'(8'h10 + k), 8'(8'ha0 + k), s0 + 4*k});
      push(d, acc);
      if (k == 4) begin
        check("full_fill",  64'(fill),      64'd4);
        check("full_ready", 64'(pkt_ready), 64'd0);
      end
      if (k == 5) begin
        check("fifth_accept_edge", 64'(acc), 64'(s0 + 5));
      end
    end
    wait_to(s0 + 23);
    check("b2b_last_amp",  64'(amp),     64'ha5);
    check("b2b_last_play", 64'(playing), 64'd1);
    wait_to(s0 + 24);
    check("b2b_end_amp",  64'(amp),     64'd0);
    check("b2b_end_play", 64'(playing), 64'd0);
    check("b2b_end_fill", 64'(fill),    64'd0);

    // D=0 means 256 ticks.
    push(24'h0020aa, acc);
    s = acc + 2;
    sb.push_back('{8'h20, 8'haa, s});
    wait_to(s + 1019);
    check("d0_amp_held",  64'(amp), 64'haa);
    wait_to(s + 1023);
    check("d0_amp_final", 64'(amp), GAP ? 64'd0 : 64'haa);
    wait_to(s + 1024);
    check("d0_amp_off",   64'(amp),     64'd0);
    check("d0_idle",      64'(playing), 64'd0);

    // Asynchronous reset mid-step with two packets buffered.
    push(24'h0230c3, acc);
    s = acc + 2;
    sb.push_back('{8'h30, 8'hc3, s});
    push(24'h0231c4, acc);
    push(24'h0232c5, acc);
    wait_to(s + 2);
    check("mid_fill", 64'(fill), 64'd2);
    check("mid_amp",  64'(amp),  64'hc3);
    #2 reset = 1'b0;
    #1;
    check("async_note",     64'(note),        64'd0);
    check("async_amp",      64'(amp),         64'd0);
    check("async_strobe",   64'(note_strobe), 64'd0);
    check("async_playing",  64'(playing),     64'd0);
    check("async_underrun", 64'(underrun),    64'd0);
    check("async_fill",     64'(fill),        64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(pkt_ready), 64'd1);
    check("post_rst_play",  64'(playing),   64'd0);

    // D=1 step never gets a gap.
    push(24'h0114ff, acc);
    s = acc + 2;
    sb.push_back('{8'h14, 8'hff, s});
    wait_to(s + 3);
    check("d1_amp_full", 64'(amp), 64'hff);
    wait_to(s + 4);
    check("d1_amp_off",  64'(amp),      64'd0);
    check("d1_underrun", 64'(underrun), 64'd1);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_sequencer.md
# note_sequencer

Step sequencer between the SPI packet receiver and the per-track tone generators. Buffers incoming note packets in a small FIFO, then applies one packet at a time to the tone-generator note/amplitude inputs for a programmed number of timebase ticks. This gives the drive tracks sample-accurate note timing independent of SPI arrival jitter. Sits inside `top` between the SPI shift register and the `nc[]` tone-generator array.

## Interface
- `NUM_TRACKS`, 1, number of tracks/tone generators driven.
- `PACKET_SIZE`, 24, bits per track in a packet.
- `FIFO_DEPTH`, 4, packet buffer depth; power of two, ≥2.
- `TICK_DIV`, 2500000, clock cycles per timebase tick; ≥2.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `pkt_valid`  in  1  packet word present on `pkt_data`.
- `pkt_data`  in  `PACKET_SIZE*NUM_TRACKS`  packet; track t in slice [24t+23:24t].
- `pkt_ready`  out  1  FIFO can accept; equals `fill < FIFO_DEPTH`.
- `note`  out  `8*NUM_TRACKS`  per-track note code to tone generators.
- `amp`  out  `8*NUM_TRACKS`  per-track amplitude; 0 = silent.
- `note_strobe`  out  1  one-cycle pulse in first cycle new `note`/`amp` values are visible.
- `playing`  out  1  high while a step is active.
- `underrun`  out  1  sticky; a step ended with FIFO empty.
- `fill`  out  `$clog2(FIFO_DEPTH)+1`  packets buffered.

## Operation
- Track slice fields: [23:16] duration, [15:8] note, [7:0] amp. Step duration comes from track 0 only; other tracks' [23:16] ignored.
- Duration D in ticks; D=0 means 256 ticks.
- Push when `pkt_valid && pkt_ready` at a rising edge; pop only when `fill>0` (registered). Push and pop same edge: `fill` unchanged, both happen.
- FSM:
  - IDLE: `playing=0`, all `amp=0`, `note` holds last value. `fill>0` → LOAD.
  - LOAD (1 cycle): pop head, register all `note`/`amp`, load remaining-ticks = D, clear tick counter → PLAY.
  - PLAY: `playing=1`; tick counter counts 0..TICK_DIV-1; at wrap remaining-ticks decrements. At wrap with remaining = 1: `fill>0` → LOAD, else → IDLE, set `underrun`, drive `amp=0`.
- `underrun` never set by leaving IDLE at startup; cleared only by reset.
- Reset asserted (any state, including mid-PLAY): immediately `note=0`, `amp=0`, `note_strobe=0`, `playing=0`, `underrun=0`, `fill=0`, FIFO pointers 0, state IDLE; `pkt_ready=1` after release.

## Timing
- Outputs registered; `pkt_ready` combinational from registered `fill` only.
- From IDLE: accept edge N → FIFO write at N; LOAD cycle; `note_strobe`/new values visible after edge N+2.
- Back-to-back steps: strobe-to-strobe interval exactly D×TICK_DIV cycles (LOAD cycle absorbed into the final tick).
- Full FIFO: `pkt_ready=0`; pop frees slot, `pkt_ready` returns next cycle.

## Configuration
- `SEQ_GAP_EN` defined: for steps with D≥2, `amp` forced to 0 during the final tick (last TICK_DIV cycles) for articulation between repeated notes; `note` held; `note_strobe` does not pulse at gap start; step interval unchanged. D=1 steps have no gap.
- Undefined: `amp` held for the full step duration.

## Test plan
Params: NUM_TRACKS=1, TICK_DIV=4, FIFO_DEPTH=4.
- Reset low then high → `note=0`, `amp=0`, `fill=0`, `pkt_ready=1`, `playing=0`, `underrun=0`.
- Push 24'h0214ff into idle block → strobe 2 edges later, `note=8'h14`, `amp=8'hff` for 8 cycles, then `amp=0`, `playing=0`, `underrun=1`.
- Push 24'h0110ff then five packets while playing → `fill` reaches 4, `pkt_ready=0`; strobes every 4 cycles; fifth push accepted only after a pop.
- Push 24'h0020aa → `amp=8'haa` for 1024 cycles (D=0 = 256 ticks).
- Assert reset 3 cycles into a step with `fill=2` → outputs 0 and `fill=0` without waiting for a clock edge.
- With `SEQ_GAP_EN`: 24'h0214ff → `amp=8'hff` 4 cycles, `amp=0` 4 cycles, `note=8'h14` throughout; 24'h0114ff → no gap.
